// File: rtl/z3_sync_pkg.sv
// Shared constants for the Zorro III bus input synchronizer and cycle monitor.
package z3_sync_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned FILT_DEF        = 2;
  localparam int unsigned TIMEOUT_DEF     = 1000;
  localparam int unsigned CNT_W           = 10;

  // Bit positions of the synchronized/filtered input vector
  localparam int unsigned NUM_BITS  = 9;
  localparam int unsigned BIT_FCS   = 0;
  localparam int unsigned BIT_DOE   = 1;
  localparam int unsigned BIT_READ  = 2;
  localparam int unsigned BIT_DTACK = 3;
  localparam int unsigned BIT_BERR  = 4;
  localparam int unsigned BIT_DS0   = 5;

  typedef enum logic [1:0] {
    CycIdle = 2'd0,
    CycAddr = 2'd1,
    CycData = 2'd2,
    CycTerm = 2'd3
  } cyc_state_e;

endpackage

// File: rtl/sync_filter.sv
// One-bit synchronizer followed by a run-length glitch filter.
module sync_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT        = 2
) (
  input  logic CLK_50M,
  input  logic IORST_n,
  input  logic din,
  output logic sync,
  output logic filt
);

  localparam int unsigned CW = $clog2(FILT + 1);
  localparam logic [CW-1:0] FILT_LAST = CW'(FILT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          run_q, run_d;
  logic                   filt_q, filt_d;

  assign sync = sync_q[SYNC_STAGES-1];
  assign filt = filt_q;

  always_ff @(posedge CLK_50M or negedge IORST_n) begin
    if (!IORST_n) begin
      sync_q <= '0;
      run_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      run_q  <= run_d;
      filt_q <= filt_d;
    end
  end

  // Any sample agreeing with the output restarts the run.
  always_comb begin
    run_d  = '0;
    filt_d = filt_q;
    if (sync != filt_q) begin
      if (run_q == FILT_LAST) begin
        filt_d = sync;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/z3_bus_sync.sv
// Zorro III bus input conditioning: synchronize/filter raw strobes, detect FCS edges,
// latch READ at cycle start and track the bus cycle with a timeout monitor.
module z3_bus_sync
  import z3_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned FILT        = FILT_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
  input  logic       CLK_50M,
  input  logic       IORST_n,
  input  logic       Z_FCS_n,
  input  logic       DOE,
  input  logic       READ,
  input  logic       DTACK_n,
  input  logic       BERR_n,
  input  logic [3:0] DS_n,
  output logic       fcs_s,
  output logic       doe_s,
  output logic       dtack_s,
  output logic       berr_s,
  output logic [3:0] ds_s,
  output logic       ds_any,
  output logic       fcs_rise,
  output logic       fcs_fall,
  output logic       read_l,
  output logic [1:0] cyc_state,
  output logic       cyc_timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  logic [NUM_BITS-1:0] raw_act, sync_v, filt_v;

  // Active-low signals are inverted ahead of the synchronizer so reset means inactive.
  assign raw_act = {~DS_n, ~BERR_n, ~DTACK_n, READ, DOE, ~Z_FCS_n};

  for (genvar i = 0; i < NUM_BITS; i++) begin : g_bit
    sync_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT       (FILT)
    ) u_sync_filter (
      .CLK_50M(CLK_50M),
      .IORST_n(IORST_n),
      .din    (raw_act[i]),
      .sync   (sync_v[i]),
      .filt   (filt_v[i])
    );
  end

  // Only READ uses its raw synchronized value; its filtered value is not needed.
  logic unused_sig;
  assign unused_sig = ^{sync_v[8:3], sync_v[1:0], filt_v[BIT_READ]};

  assign fcs_s   = filt_v[BIT_FCS];
  assign doe_s   = filt_v[BIT_DOE];
  assign dtack_s = filt_v[BIT_DTACK];
  assign berr_s  = filt_v[BIT_BERR];
  assign ds_s    = filt_v[BIT_DS0 +: 4];
  assign ds_any  = |ds_s;

  logic             fcs_q;
  logic             read_q;
  cyc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             term;

  assign fcs_rise  = fcs_s & ~fcs_q;
  assign fcs_fall  = ~fcs_s & fcs_q;
  assign read_l    = read_q;
  assign cyc_state = state_q;
  assign term      = dtack_s | berr_s;

  always_ff @(posedge CLK_50M or negedge IORST_n) begin
    if (!IORST_n) begin
      fcs_q   <= 1'b0;
      read_q  <= 1'b0;
      state_q <= CycIdle;
      cnt_q   <= '0;
    end else begin
      fcs_q   <= fcs_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fcs_rise) begin
        read_q <= sync_v[BIT_READ];
      end
    end
  end

  // FCS negation overrides everything; termination beats a coincident timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_timeout = 1'b0;
    if (!fcs_s) begin
      state_d = CycIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        CycIdle: begin
          cnt_d = '0;
          if (fcs_rise) begin
            state_d = CycAddr;
          end
        end
        CycAddr, CycData: begin
          if (term) begin
            state_d = CycTerm;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d     = CycTerm;
            cyc_timeout = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (state_q == CycAddr && ds_any && doe_s) begin
              state_d = CycData;
            end
          end
        end
        CycTerm: cnt_d = '0;
        default: state_d = CycIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_z3_bus_sync.sv
// Directed bench for z3_bus_sync: expectations are queued per cycle and checked on the falling edge.
module tb_z3_bus_sync;

  logic       CLK_50M = 1'b0;
  logic       IORST_n = 1'b0;
  logic       Z_FCS_n = 1'b1;
  logic       DOE     = 1'b0;
  logic       READ    = 1'b0;
  logic       DTACK_n = 1'b1;
  logic       BERR_n  = 1'b1;
  logic [3:0] DS_n    = 4'hF;
  logic       fcs_s, doe_s, dtack_s, berr_s, ds_any, fcs_rise, fcs_fall, read_l, cyc_timeout;
  logic [3:0] ds_s;
  logic [1:0] cyc_state;

  z3_bus_sync dut (
    .CLK_50M    (CLK_50M),
    .IORST_n    (IORST_n),
    .Z_FCS_n    (Z_FCS_n),
    .DOE        (DOE),
    .READ       (READ),
    .DTACK_n    (DTACK_n),
    .BERR_n     (BERR_n),
    .DS_n       (DS_n),
    .fcs_s      (fcs_s),
    .doe_s      (doe_s),
    .dtack_s    (dtack_s),
    .berr_s     (berr_s),
    .ds_s       (ds_s),
    .ds_any     (ds_any),
    .fcs_rise   (fcs_rise),
    .fcs_fall   (fcs_fall),
    .read_l     (read_l),
    .cyc_state  (cyc_state),
    .cyc_timeout(cyc_timeout)
  );

  always #10 CLK_50M = ~CLK_50M;

  localparam int S_FCS = 0, S_RISE = 1, S_FALL = 2, S_DS = 3, S_DSANY = 4, S_DOE = 5;
  localparam int S_DTACK = 6, S_BERR = 7, S_READL = 8, S_STATE = 9, S_TOUT = 10, S_TCNT = 11;

  typedef struct {
    int unsigned cyc;
    int          sel;
    logic [3:0]  val;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          failed = 0;
  int          tout_cnt = 0;
  int unsigned c0;

  always @(posedge CLK_50M) cyc++;

  function automatic logic [3:0] sample(int sel);
    case (sel)
      S_FCS:   return {3'b000, fcs_s};
      S_RISE:  return {3'b000, fcs_rise};
      S_FALL:  return {3'b000, fcs_fall};
      S_DS:    return ds_s;
      S_DSANY: return {3'b000, ds_any};
      S_DOE:   return {3'b000, doe_s};
      S_DTACK: return {3'b000, dtack_s};
      S_BERR:  return {3'b000, berr_s};
      S_READL: return {3'b000, read_l};
      S_STATE: return {2'b00, cyc_state};
      S_TOUT:  return {3'b000, cyc_timeout};
      default: return tout_cnt[3:0];
    endcase
  endfunction

  task automatic check(string tag, logic [3:0] obs, logic [3:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Keep the queue ordered by cycle so the checker only ever looks at the head.
  task automatic expect_at(int unsigned c, int sel, logic [3:0] v, string tag);
    exp_t e;
    int   pos;
    e.cyc = c;
    e.sel = sel;
    e.val = v;
    e.tag = tag;
    pos = sbq.size();
    for (int i = 0; i < sbq.size(); i++) begin
      if (sbq[i].cyc > c) begin
        pos = i;
        break;
      end
    end
    sbq.insert(pos, e);
  endtask

  always @(negedge CLK_50M) begin
    exp_t e;
    if (cyc_timeout === 1'b1) tout_cnt++;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      check(e.tag, sample(e.sel), e.val);
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge CLK_50M);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(3);
    check("rst_fcs_s", sample(S_FCS), 4'h0);
    check("rst_ds_s", sample(S_DS), 4'h0);
    check("rst_state", sample(S_STATE), 4'h0);
    check("rst_read_l", sample(S_READL), 4'h0);
    check("rst_timeout", sample(S_TOUT), 4'h0);
    IORST_n = 1'b1;
    tick(3);

    // FCS assertion latency and monitor entry
    c0 = cyc;
    Z_FCS_n = 1'b0;
    expect_at(c0 + 3, S_FCS, 4'h0, "fcs_s_early");
    expect_at(c0 + 3, S_RISE, 4'h0, "rise_early");
    expect_at(c0 + 4, S_FCS, 4'h1, "fcs_s_lat4");
    expect_at(c0 + 4, S_RISE, 4'h1, "rise_lat4");
    expect_at(c0 + 4, S_STATE, 4'h0, "state_idle_c4");
    expect_at(c0 + 5, S_RISE, 4'h0, "rise_single");
    expect_at(c0 + 5, S_STATE, 4'h1, "state_addr_c5");
    tick(8);

    // One-cycle DS glitch is filtered away
    c0 = cyc;
    DS_n[2] = 1'b0;
    tick(1);
    DS_n[2] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      expect_at(c0 + k, S_DS, 4'h0, "glitch_ds_s");
      expect_at(c0 + k, S_STATE, 4'h1, "glitch_state");
    end
    tick(8);

    c0 = cyc;
    Z_FCS_n = 1'b1;
    expect_at(c0 + 4, S_FALL, 4'h1, "fall_pulse");
    expect_at(c0 + 4, S_STATE, 4'h1, "state_before_idle");
    expect_at(c0 + 5, S_FALL, 4'h0, "fall_single");
    expect_at(c0 + 5, S_STATE, 4'h0, "state_idle_after");
    tick(8);

    // Full read cycle
    c0 = cyc;
    Z_FCS_n = 1'b0;
    READ = 1'b1;
    expect_at(c0 + 4, S_READL, 4'h0, "read_l_before");
    expect_at(c0 + 5, S_READL, 4'h1, "read_l_latched");
    expect_at(c0 + 5, S_STATE, 4'h1, "rd_addr");
    tick(5);
    DOE = 1'b1;
    DS_n = 4'h0;
    expect_at(c0 + 9, S_DS, 4'hF, "rd_ds_s");
    expect_at(c0 + 9, S_DSANY, 4'h1, "rd_ds_any");
    expect_at(c0 + 9, S_DOE, 4'h1, "rd_doe_s");
    expect_at(c0 + 9, S_STATE, 4'h1, "rd_still_addr");
    expect_at(c0 + 10, S_STATE, 4'h2, "rd_data");
    tick(7);
    DTACK_n = 1'b0;
    expect_at(c0 + 16, S_DTACK, 4'h1, "rd_dtack_s");
    expect_at(c0 + 16, S_STATE, 4'h2, "rd_data_hold");
    expect_at(c0 + 17, S_STATE, 4'h3, "rd_term");
    tick(8);
    Z_FCS_n = 1'b1;
    DTACK_n = 1'b1;
    DOE = 1'b0;
    DS_n = 4'hF;
    READ = 1'b0;
    expect_at(c0 + 24, S_STATE, 4'h3, "rd_term_hold");
    expect_at(c0 + 25, S_STATE, 4'h0, "rd_idle");
    expect_at(c0 + 25, S_READL, 4'h1, "read_l_hold");
    expect_at(c0 + 26, S_TCNT, 4'h0, "rd_no_timeout");
    tick(30);

    // Timeout with DS but no termination
    c0 = cyc;
    Z_FCS_n = 1'b0;
    DS_n = 4'h0;
    expect_at(c0 + 1003, S_TOUT, 4'h0, "to_not_yet");
    expect_at(c0 + 1004, S_TOUT, 4'h1, "to_pulse");
    expect_at(c0 + 1004, S_STATE, 4'h1, "to_addr");
    expect_at(c0 + 1005, S_TOUT, 4'h0, "to_single");
    expect_at(c0 + 1005, S_STATE, 4'h3, "to_term");
    expect_at(c0 + 1100, S_TCNT, 4'h1, "to_count");
    expect_at(c0 + 1100, S_STATE, 4'h3, "to_term_hold");
    tick(1110);
    c0 = cyc;
    Z_FCS_n = 1'b1;
    DS_n = 4'hF;
    expect_at(c0 + 5, S_STATE, 4'h0, "to_idle");
    expect_at(c0 + 5, S_TCNT, 4'h1, "to_count_final");
    tick(10);

    // BERR coincident with the timeout cycle: termination wins
    c0 = cyc;
    Z_FCS_n = 1'b0;
    expect_at(c0 + 1003, S_BERR, 4'h0, "berr_not_yet");
    expect_at(c0 + 1004, S_BERR, 4'h1, "berr_s");
    expect_at(c0 + 1004, S_TOUT, 4'h0, "berr_no_pulse");
    expect_at(c0 + 1004, S_STATE, 4'h1, "berr_addr");
    expect_at(c0 + 1005, S_STATE, 4'h3, "berr_term");
    expect_at(c0 + 1005, S_TCNT, 4'h1, "berr_count");
    tick(1000);
    BERR_n = 1'b0;
    tick(10);
    Z_FCS_n = 1'b1;
    BERR_n = 1'b1;
    tick(10);

    // Reset during DATA, released with FCS still asserted
    c0 = cyc;
    Z_FCS_n = 1'b0;
    tick(5);
    DOE = 1'b1;
    DS_n = 4'h0;
    tick(8);
    check("pre_rst_data", sample(S_STATE), 4'h2);
    IORST_n = 1'b0;
    #1;
    check("mid_rst_fcs_s", sample(S_FCS), 4'h0);
    check("mid_rst_ds_s", sample(S_DS), 4'h0);
    check("mid_rst_ds_any", sample(S_DSANY), 4'h0);
    check("mid_rst_doe_s", sample(S_DOE), 4'h0);
    check("mid_rst_state", sample(S_STATE), 4'h0);
    check("mid_rst_read_l", sample(S_READL), 4'h0);
    check("mid_rst_rise", sample(S_RISE), 4'h0);
    tick(3);
    IORST_n = 1'b1;
    c0 = cyc;
    expect_at(c0 + 3, S_RISE, 4'h0, "rel_rise_early");
    expect_at(c0 + 4, S_RISE, 4'h1, "rel_rise_c4");
    expect_at(c0 + 4, S_FCS, 4'h1, "rel_fcs_s");
    expect_at(c0 + 5, S_STATE, 4'h1, "rel_addr");
    expect_at(c0 + 6, S_STATE, 4'h2, "rel_data");
    tick(10);
    Z_FCS_n = 1'b1;
    DOE = 1'b0;
    DS_n = 4'hF;

    for (int i = 0; i < 50 && sbq.size() > 0; i++) tick(1);
    check("sb_drain", 4'(sbq.size()), 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
